// File: rtl/freqdiv_period_meter.sv
// Measures period and high time of an asynchronous divided clock in wb_clk_i cycles,
// flags lock on repeated equal periods and a stalled input. Define FREQMETER_CHECK_EN for the expected-period compare.
module freqdiv_period_meter #(
   parameter int CNT_W       = 8,
   parameter int LOCK_CNT    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             en,
   input  logic             sig_in,
`ifdef FREQMETER_CHECK_EN
   input  logic [3:0]       exp_n,
   output logic             mismatch_o,
`endif
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_o,
   output logic             valid_o,
   output logic             locked_o,
   output logic             ovf_o
);

   // state | meaning
   // IDLE  | disabled, everything cleared
   // ARM   | waiting for the first synced rising edge; still times out on a stall
   // MEAS  | counting between rising edges, reporting each completed period
   typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

   localparam int M_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [M_W-1:0] MATCH_MAX = M_W'(LOCK_CNT);

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_d;
   logic                   rise;
   logic [CNT_W-1:0]       period_cnt;
   logic [CNT_W-1:0]       high_cnt;
   logic [M_W-1:0]         match_cnt;
   logic [M_W-1:0]         match_nxt;

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;

   // The synchronizer runs regardless of en so edge history is valid when enabled.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_d    <= s;
      end
   end

   always_comb begin
      match_nxt = M_W'(1);
      if (period_cnt == period_o && match_cnt != '0)
         match_nxt = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + M_W'(1);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_cnt   <= '0;
         match_cnt  <= '0;
         period_o   <= '0;
         high_o     <= '0;
         valid_o    <= 1'b0;
         locked_o   <= 1'b0;
         ovf_o      <= 1'b0;
`ifdef FREQMETER_CHECK_EN
         mismatch_o <= 1'b0;
`endif
      end else if (!en) begin
         state      <= IDLE;
         period_cnt <= '0;
         high_cnt   <= '0;
         match_cnt  <= '0;
         period_o   <= '0;
         high_o     <= '0;
         valid_o    <= 1'b0;
         locked_o   <= 1'b0;
         ovf_o      <= 1'b0;
`ifdef FREQMETER_CHECK_EN
         mismatch_o <= 1'b0;
`endif
      end else begin
         valid_o <= 1'b0;
`ifdef FREQMETER_CHECK_EN
         mismatch_o <= 1'b0;
`endif
         case (state)
            IDLE: begin
               state      <= ARM;
               period_cnt <= '0;
               high_cnt   <= '0;
            end
            ARM: begin
               if (rise) begin
                  state      <= MEAS;
                  period_cnt <= CNT_W'(1);
                  high_cnt   <= CNT_W'(1);
               end else if (period_cnt == CNT_MAX) begin
                  ovf_o      <= 1'b1;
                  locked_o   <= 1'b0;
                  match_cnt  <= '0;
                  period_cnt <= '0;
               end else begin
                  period_cnt <= period_cnt + CNT_W'(1);
               end
            end
            MEAS: begin
               // A rise on the terminal count still completes a max-length period.
               if (rise) begin
                  period_o   <= period_cnt;
                  high_o     <= high_cnt;
                  valid_o    <= 1'b1;
                  match_cnt  <= match_nxt;
                  locked_o   <= (match_nxt == MATCH_MAX);
`ifdef FREQMETER_CHECK_EN
                  mismatch_o <= (period_cnt != CNT_W'(exp_n));
`endif
                  period_cnt <= CNT_W'(1);
                  high_cnt   <= CNT_W'(1);
               end else if (period_cnt == CNT_MAX) begin
                  state      <= ARM;
                  ovf_o      <= 1'b1;
                  locked_o   <= 1'b0;
                  match_cnt  <= '0;
                  period_cnt <= '0;
                  high_cnt   <= '0;
               end else begin
                  period_cnt <= period_cnt + CNT_W'(1);
                  if (s)
                     high_cnt <= high_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_freqdiv_period_meter.sv
// Randomized bench for freqdiv_period_meter: sig_in waveforms are recorded per cycle and
// expected outputs are derived from rising-edge positions and high-level counts of that record.
module tb_freqdiv_period_meter;
   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int NC       = 16384;
   localparam int LAT      = 3;

   logic             wb_clk_i = 1'b0;
   logic             wb_rst_i;
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] period_o;
   logic [CNT_W-1:0] high_o;
   logic             valid_o;
   logic             locked_o;
   logic             ovf_o;
`ifdef FREQMETER_CHECK_EN
   logic [3:0]       exp_n;
   logic             mismatch_o;
`endif

   freqdiv_period_meter #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(2)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .en       (en),
      .sig_in   (sig_in),
`ifdef FREQMETER_CHECK_EN
      .exp_n    (exp_n),
      .mismatch_o (mismatch_o),
`endif
      .period_o (period_o),
      .high_o   (high_o),
      .valid_o  (valid_o),
      .locked_o (locked_o),
      .ovf_o    (ovf_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   bit w_arr [NC];
   bit en_arr[NC];
   int cyc;
   int n_vec;
   int n_err;

   // reference state: rise positions, not counters
   bit m_idle;
   bit m_armed;
   int m_last;
   int m_arm_start;
   int m_run;
   bit e_valid;
   bit e_locked;
   bit e_ovf;
   int e_period;
   int e_high;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic model_clear();
      m_idle   = 1'b1;
      m_armed  = 1'b0;
      m_run    = 0;
      e_valid  = 1'b0;
      e_locked = 1'b0;
      e_ovf    = 1'b0;
      e_period = 0;
      e_high   = 0;
   endtask

   task automatic model_step();
      int  r;
      int  per;
      int  hi;
      bit  rise;
      e_valid = 1'b0;
      if (!en_arr[cyc-1]) begin
         model_clear();
      end else if (m_idle) begin
         m_idle      = 1'b0;
         m_armed     = 1'b0;
         m_arm_start = cyc;
      end else begin
         r    = cyc - LAT;
         rise = w_arr[r] && !w_arr[r-1];
         if (!m_armed) begin
            if (rise) begin
               m_armed = 1'b1;
               m_last  = r;
            end else if (cyc - m_arm_start == 256) begin
               e_ovf       = 1'b1;
               e_locked    = 1'b0;
               m_run       = 0;
               m_arm_start = cyc;
            end
         end else if (rise) begin
            per = r - m_last;
            hi  = 0;
            for (int k = m_last; k < r; k++) hi += int'(w_arr[k]);
            if (m_run > 0 && per == e_period) m_run++;
            else m_run = 1;
            e_locked = (m_run >= LOCK_CNT);
            e_period = per;
            e_high   = hi;
            e_valid  = 1'b1;
            m_last   = r;
         end else if (r - m_last == 255) begin
            e_ovf       = 1'b1;
            e_locked    = 1'b0;
            m_run       = 0;
            m_armed     = 1'b0;
            m_arm_start = cyc;
         end
      end
   endtask

   task automatic check_all(input string ph);
      check_val({ph, ".valid"},  32'(valid_o),  32'(e_valid));
      check_val({ph, ".period"}, 32'(period_o), 32'(e_period));
      check_val({ph, ".high"},   32'(high_o),   32'(e_high));
      check_val({ph, ".locked"}, 32'(locked_o), 32'(e_locked));
      check_val({ph, ".ovf"},    32'(ovf_o),    32'(e_ovf));
`ifdef FREQMETER_CHECK_EN
      check_val({ph, ".mismatch"}, 32'(mismatch_o),
                32'(e_valid && (e_period != int'(exp_n))));
`endif
   endtask

   string phase;

   task automatic tick(input bit nxt_sig, input bit nxt_en);
      @(posedge wb_clk_i);
      #1;
      cyc++;
      model_step();
      check_all(phase);
      sig_in      = nxt_sig;
      en          = nxt_en;
      w_arr[cyc]  = nxt_sig;
      en_arr[cyc] = nxt_en;
   endtask

   task automatic hold(input bit v, input int n, input bit e);
      for (int i = 0; i < n; i++) tick(v, e);
   endtask

   task automatic wave(input int hi, input int lo, input int reps);
      for (int i = 0; i < reps; i++) begin
         hold(1'b1, hi, 1'b1);
         hold(1'b0, lo, 1'b1);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cyc   = 0;
      wb_rst_i = 1'b1;
      en       = 1'b0;
      sig_in   = 1'b0;
`ifdef FREQMETER_CHECK_EN
      exp_n = 4'd6;
`endif
      w_arr[0]  = 1'b0;
      en_arr[0] = 1'b0;
      model_clear();
      #2;
      phase = "reset";
      check_all(phase);
      #21 wb_rst_i = 1'b0;
      hold(1'b0, 8, 1'b0);
      hold(1'b0, 6, 1'b1);

      phase = "p6";
      wave(3, 3, 8);
`ifdef FREQMETER_CHECK_EN
      exp_n = 4'd5;
`endif
      phase = "p5";
      wave(3, 2, 8);
      phase = "p6b";
      wave(3, 3, 6);
      phase = "p8";
      wave(4, 4, 8);

      phase = "rand";
      for (int i = 0; i < 25; i++) begin
`ifdef FREQMETER_CHECK_EN
         exp_n = 4'($urandom_range(2, 15));
`endif
         wave(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
              int'($urandom_range(1, 6)));
      end
      phase = "pmin";
      wave(1, 1, 6);

      phase = "p255";
      wave(1, 254, 3);
      phase = "p256";
      wave(1, 255, 2);
      phase = "ovf_clr";
      hold(1'b0, 1, 1'b0);
      hold(1'b0, 6, 1'b1);

      phase = "en_drop";
      wave(3, 3, 6);
      hold(1'b1, 2, 1'b1);
      hold(1'b1, 1, 1'b0);
      hold(1'b0, 6, 1'b0);
      hold(1'b0, 6, 1'b1);
      wave(3, 3, 2);

      phase = "stuck_hi";
      hold(1'b0, 2, 1'b0);
      hold(1'b1, 6, 1'b0);
      hold(1'b1, 300, 1'b1);
      phase = "stuck_clr";
      hold(1'b1, 1, 1'b0);
      hold(1'b1, 3, 1'b1);
      hold(1'b0, 6, 1'b0);

      phase = "rst_pulse";
      hold(1'b0, 6, 1'b1);
      wave(3, 3, 6);
      hold(1'b1, 2, 1'b1);
      #2;
      wb_rst_i    = 1'b1;
      en          = 1'b0;
      sig_in      = 1'b0;
      en_arr[cyc] = 1'b0;
      w_arr[cyc]  = 1'b0;
      #1;
      model_clear();
      check_all("rst_async");
      #2 wb_rst_i = 1'b0;
      hold(1'b0, 6, 1'b0);
      hold(1'b0, 6, 1'b1);
      phase = "recover";
      wave(3, 3, 6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
